spi_arbiter: RTL and testbench

- Shares the single SPI master (spi_master_2 start/tdat/done/rdata handshake) between two byte-stream requesters: requester 0 is the TFT display, requester 1 is the SD card.
- Owns chip-select sequencing, TFT D/C steering, burst grant and round-robin arbitration.
- Sits between the MMIO/streaming logic and spi_master_2 in the OTTER wrapper.
- Runs entirely on the system clock. SPI_DONE and SPI_RDATA arrive already synchronised to CLK.

---
 rtl/spi_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Shares one byte-oriented SPI master (start/tdat/done/rdata handshake)
//   between two byte-stream requesters: [0] = TFT display, [1] = SD card.
//   Handles chip-select setup/hold sequencing, TFT D/C steering, burst
//   ownership (a granted requester keeps the bus until its LAST byte) and
//   round-robin arbitration when both requesters ask at once.
//
// Ports
//   CLK, RSTB        system clock, synchronous active-low reset
//   REQ_VALID[1:0]   per-requester byte valid
//   REQ0_DATA        TFT transmit byte
//   REQ1_DATA        SD transmit byte
//   REQ_LAST[1:0]    byte closes its burst (sampled with the byte)
//   REQ0_DC          TFT data/command flag (sampled with the byte)
//   REQ_READY[1:0]   one-cycle pulse: byte accepted
//   RSP_VALID[1:0]   one-cycle pulse: RSP_DATA valid for that requester
//   RSP_DATA         received byte
//   SPI_START        start request to the SPI master
//   SPI_TDATA        byte to transmit
//   SPI_DONE         SPI master done level (already synchronous to CLK)
//   SPI_RDATA        SPI master received byte
//   CS_SEL[1:0]      one-hot active-high device select
//   TFT_DC           D/C line, updated with each TFT byte
//   GRANT            current or most recent owner
//   BUSY             state is not IDLE
//   TIMEOUT_ERR      sticky abort flag, cleared on the next grant
module spi_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic [1:0] REQ_VALID,
  input  logic [7:0] REQ0_DATA,
  input  logic [7:0] REQ1_DATA,
  input  logic [1:0] REQ_LAST,
  input  logic       REQ0_DC,
  output logic [1:0] REQ_READY,
  output logic [1:0] RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       SPI_START,
  output logic [7:0] SPI_TDATA,
  input  logic       SPI_DONE,
  input  logic [7:0] SPI_RDATA,
  output logic [1:0] CS_SEL,
  output logic       TFT_DC,
  output logic       GRANT,
  output logic       BUSY,
  output logic       TIMEOUT_ERR
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, START_WAIT, XFER, RESP, HOLD
  } state_t;

  localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;        // shared CS setup / hold counter
  logic [TW-1:0] tcnt, tcnt_n;      // per-byte watchdog
  logic          last_q, last_n;
  logic          grant_n;
  logic [1:0]    cs_n, ready_n, rvalid_n;
  logic [7:0]    rdata_n, tdata_n;
  logic          start_n, dc_n, terr_n;
  logic          pick;

  assign BUSY = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    tcnt_n   = tcnt;
    last_n   = last_q;
    grant_n  = GRANT;
    cs_n     = CS_SEL;
    ready_n  = '0;
    rvalid_n = '0;
    rdata_n  = RSP_DATA;
    tdata_n  = SPI_TDATA;
    start_n  = SPI_START;
    dc_n     = TFT_DC;
    terr_n   = TIMEOUT_ERR;
    pick     = 1'b0;

    case (state)
      IDLE: begin
        if (REQ_VALID != 2'b00) begin
          // On a tie, hand the bus to whoever did not own it last.
          pick     = (REQ_VALID == 2'b11) ? ~GRANT : REQ_VALID[1];
          grant_n  = pick;
          cs_n     = pick ? 2'b10 : 2'b01;
          terr_n   = 1'b0;
          cnt_n    = '0;
          state_n  = SETUP;
        end
      end

      SETUP: begin
        if (cnt == CW'(CS_SETUP - 1)) state_n = LOAD;
        else                          cnt_n   = cnt + CW'(1);
      end

      // CS stays asserted while the owner has nothing to send; no watchdog
      // here so a slow producer can stall mid-burst indefinitely.
      LOAD: begin
        if (REQ_VALID[GRANT]) begin
          tdata_n        = GRANT ? REQ1_DATA : REQ0_DATA;
          last_n         = REQ_LAST[GRANT];
          if (!GRANT) dc_n = REQ0_DC;
          ready_n[GRANT] = 1'b1;
          start_n        = 1'b1;
          tcnt_n         = '0;
          state_n        = START_WAIT;
        end
      end

      // The master drops DONE once it has taken the start request.
      START_WAIT: begin
        if (!SPI_DONE) begin
          start_n = 1'b0;
          state_n = XFER;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          start_n = 1'b0;
          terr_n  = 1'b1;
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          tcnt_n  = tcnt + TW'(1);
        end
      end

      XFER: begin
        if (SPI_DONE) begin
          rdata_n         = SPI_RDATA;
          rvalid_n[GRANT] = 1'b1;
          state_n         = RESP;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          start_n = 1'b0;
          terr_n  = 1'b1;
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          tcnt_n  = tcnt + TW'(1);
        end
      end

      // Grant is kept across LOAD so bursts never interleave.
      RESP: begin
        if (last_q) begin
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          state_n = LOAD;
        end
      end

      HOLD: begin
        if (cnt == CW'(CS_HOLD - 1)) begin
          cs_n    = 2'b00;
          state_n = IDLE;
        end else begin
          cnt_n   = cnt + CW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      last_q      <= 1'b0;
      GRANT       <= 1'b1;
      CS_SEL      <= 2'b00;
      REQ_READY   <= 2'b00;
      RSP_VALID   <= 2'b00;
      RSP_DATA    <= 8'h00;
      SPI_TDATA   <= 8'h00;
      SPI_START   <= 1'b0;
      TFT_DC      <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      tcnt        <= tcnt_n;
      last_q      <= last_n;
      GRANT       <= grant_n;
      CS_SEL      <= cs_n;
      REQ_READY   <= ready_n;
      RSP_VALID   <= rvalid_n;
      RSP_DATA    <= rdata_n;
      SPI_TDATA   <= tdata_n;
      SPI_START   <= start_n;
      TFT_DC      <= dc_n;
      TIMEOUT_ERR <= terr_n;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TIMEOUT  = 16;

  logic       CLK = 1'b0;
  logic       RSTB;
  logic [1:0] REQ_VALID, REQ_LAST, REQ_READY, RSP_VALID, CS_SEL;
  logic [7:0] REQ0_DATA, REQ1_DATA, RSP_DATA, SPI_TDATA, SPI_RDATA;
  logic       REQ0_DC, SPI_START, SPI_DONE, TFT_DC, GRANT, BUSY, TIMEOUT_ERR;
  logic       v0, v1, l0, l1;

  assign REQ_VALID = {v1, v0};
  assign REQ_LAST  = {l1, l0};

  always #5 CLK = ~CLK;

  spi_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTB(RSTB), .REQ_VALID(REQ_VALID), .REQ0_DATA(REQ0_DATA),
    .REQ1_DATA(REQ1_DATA), .REQ_LAST(REQ_LAST), .REQ0_DC(REQ0_DC),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .SPI_START(SPI_START), .SPI_TDATA(SPI_TDATA), .SPI_DONE(SPI_DONE),
    .SPI_RDATA(SPI_RDATA), .CS_SEL(CS_SEL), .TFT_DC(TFT_DC), .GRANT(GRANT),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR));

  int         total = 0, bad = 0;
  logic [8:0] sb[$];        // expected {requester, response byte}
  int         cs_order[$];  // owner at each CS assertion
  logic [1:0] prev_cs = 2'b00;
  logic       exp_dc = 1'b0;
  logic       spi_dead = 1'b0;
  int         rdy1_cnt = 0, rsp1_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI master model: done is high while idle, drops the cycle after a
  // start is seen, rises again 5 cycles later with TDATA^8'h99.
  logic       m_busy;
  logic [2:0] m_cnt;
  logic [7:0] m_rd;
  always @(posedge CLK) begin
    if (!RSTB) begin
      m_busy <= 1'b0; m_cnt <= '0; SPI_DONE <= 1'b1; SPI_RDATA <= 8'h00;
    end else if (spi_dead) begin
      SPI_DONE <= 1'b1;
    end else if (!m_busy) begin
      if (SPI_START) begin
        m_busy <= 1'b1; m_cnt <= 3'd5; SPI_DONE <= 1'b0; m_rd <= SPI_TDATA ^ 8'h99;
      end
    end else if (m_cnt == 3'd1) begin
      m_busy <= 1'b0; SPI_DONE <= 1'b1; SPI_RDATA <= m_rd;
    end else begin
      m_cnt <= m_cnt - 3'd1;
    end
  end

  // Response scoreboard and CS sequencing monitor.
  always @(negedge CLK) begin
    if (RSTB) begin
      if (RSP_VALID != 2'b00) begin
        if (sb.size() == 0) chk("rsp_unexp", RSP_VALID, 0);
        else begin
          chk("rsp_vld", RSP_VALID, sb[0][8] ? 2 : 1);
          chk("rsp_data", RSP_DATA, sb[0][7:0]);
          chk("tft_dc", TFT_DC, exp_dc);
          void'(sb.pop_front());
        end
      end
      if (prev_cs == 2'b00 && CS_SEL != 2'b00) begin
        cs_order.push_back(CS_SEL[1] ? 1 : 0);
        chk("cs_onehot", (CS_SEL == 2'b01) || (CS_SEL == 2'b10), 1);
      end
      if (prev_cs != 2'b00 && CS_SEL != prev_cs) chk("cs_gap", CS_SEL, 0);
      rdy1_cnt <= rdy1_cnt + int'(REQ_READY[1]);
      rsp1_cnt <= rsp1_cnt + int'(RSP_VALID[1]);
    end
    prev_cs <= CS_SEL;
  end

  task automatic send_byte(input int id, input logic [7:0] d, input logic last,
                           input logic dc, input bit exp_rsp, output int lat);
    bit got = 0;
    if (id == 0) begin REQ0_DATA = d; l0 = last; REQ0_DC = dc; v0 = 1'b1; end
    else         begin REQ1_DATA = d; l1 = last; v1 = 1'b1; end
    lat = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge CLK);
      lat++;
      if (REQ_READY[id]) got = 1;
    end
    if (!got) chk($sformatf("rdy_to%0d", id), REQ_READY[id], 1);
    else begin
      if (exp_rsp) sb.push_back({id[0], d ^ 8'h99});
      if (id == 0) exp_dc = dc;
    end
    if (id == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge CLK);
      if (!BUSY && sb.size() == 0) ok = 1;
    end
    if (!ok) begin
      chk("idle_to_busy", BUSY, 0);
      chk("idle_to_sb", sb.size(), 0);
    end
  endtask

  task automatic do_reset();
    RSTB = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(negedge CLK);
    RSTB = 1'b1; exp_dc = 1'b0; sb.delete();
    @(negedge CLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int lat, la, lb, n, s_rdy, s_rsp;
    bit seen;
    v0 = 0; v1 = 0; l0 = 0; l1 = 0;
    REQ0_DATA = 0; REQ1_DATA = 0; REQ0_DC = 0;
    RSTB = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_outs", {REQ_READY, RSP_VALID, RSP_DATA, SPI_START, SPI_TDATA,
                     CS_SEL, TFT_DC, BUSY, TIMEOUT_ERR}, 0);
    chk("rst_grant", GRANT, 1);
    RSTB = 1'b1;
    @(negedge CLK);

    // Single TFT byte
    send_byte(0, 8'hA5, 1, 1, 1, lat);
    chk("latency", lat, CS_SETUP + 2);
    for (int i = 0; i < 20 && !SPI_START; i++) @(negedge CLK);
    chk("t1_cs", CS_SEL, 2'b01);
    chk("t1_dc", TFT_DC, 1);
    chk("t1_tdata", SPI_TDATA, 8'hA5);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (RSP_VALID[0]) seen = 1;
    end
    chk("t1_rsp_seen", seen, 1);
    n = 0;
    for (int i = 0; i < 20 && CS_SEL != 2'b00; i++) begin
      @(negedge CLK);
      n++;
    end
    chk("t1_cs_hold", n, CS_HOLD + 1);
    chk("t1_idle", BUSY, 0);
    wait_idle();

    // Tie-break from reset and alternation
    do_reset();
    cs_order.delete();
    for (int k = 0; k < 3; k++) begin
      fork
        send_byte(0, 8'h10 + 8'(k), 1, 1, 1, la);
        send_byte(1, 8'h20 + 8'(k), 1, 0, 1, lb);
      join
      wait_idle();
    end
    chk("t2_norder", cs_order.size(), 6);
    for (int i = 0; i < 6 && i < cs_order.size(); i++)
      chk($sformatf("t2_order%0d", i), cs_order[i], i % 2);

    // SD 4-byte burst with TFT waiting throughout
    cs_order.delete();
    s_rdy = rdy1_cnt; s_rsp = rsp1_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send_byte(1, 8'(i + 1), (i == 3), 0, 1, la);
      end
      begin
        @(negedge CLK);
        send_byte(0, 8'h77, 1, 0, 1, lb);
      end
    join
    wait_idle();
    chk("t3_norder", cs_order.size(), 2);
    if (cs_order.size() == 2) begin
      chk("t3_first", cs_order[0], 1);
      chk("t3_second", cs_order[1], 0);
    end
    chk("t3_rdy1", rdy1_cnt - s_rdy, 4);
    chk("t3_rsp1", rsp1_cnt - s_rsp, 4);

    // SD burst stalled in LOAD
    send_byte(1, 8'h55, 0, 0, 1, la);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
    repeat (50) @(negedge CLK);
    chk("t4_cs", CS_SEL, 2'b10);
    chk("t4_busy", BUSY, 1);
    chk("t4_terr", TIMEOUT_ERR, 0);
    send_byte(1, 8'h66, 1, 0, 1, la);
    wait_idle();

    // Timeout with a master that never drops DONE
    spi_dead = 1'b1;
    send_byte(0, 8'h42, 1, 1, 0, la);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!SPI_START) break;
      n++;
      @(negedge CLK);
    end
    chk("t5_start_len", n, TIMEOUT);
    chk("t5_terr", TIMEOUT_ERR, 1);
    wait_idle();
    chk("t5_sticky", TIMEOUT_ERR, 1);
    spi_dead = 1'b0;
    repeat (3) @(negedge CLK);
    send_byte(0, 8'h43, 1, 1, 1, la);
    chk("t5_clr", TIMEOUT_ERR, 0);
    wait_idle();

    // Reset during XFER
    send_byte(0, 8'h5A, 1, 1, 0, la);
    for (int i = 0; i < 20 && SPI_START; i++) @(negedge CLK);
    RSTB = 1'b0;
    @(negedge CLK);
    chk("t6_outs", {REQ_READY, RSP_VALID, RSP_DATA, SPI_START, SPI_TDATA,
                    CS_SEL, TFT_DC, BUSY, TIMEOUT_ERR}, 0);
    chk("t6_grant", GRANT, 1);
    RSTB = 1'b1; exp_dc = 1'b0; sb.delete();
    repeat (10) @(negedge CLK);
    send_byte(0, 8'h81, 1, 0, 1, lat);
    chk("t6_latency", lat, CS_SETUP + 2);
    wait_idle();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
